// File: rtl/lifo_arbiter.sv
// lifo_arbiter: round-robin sharing of one registered-I/O LIFO between NCLI clients,
// with shadow occupancy, pop-data return routing and flush sequencing.
module lifo_arbiter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3,
  parameter int NCLI   = 2,
  parameter int RD_LAT = 3
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   flush_i,
  input  logic [NCLI-1:0]        req_i,
  input  logic [NCLI-1:0]        op_i,
  input  logic [NCLI*DWIDTH-1:0] data_i,
  output logic [NCLI-1:0]        gnt_o,
  output logic [NCLI-1:0]        err_o,
  output logic [NCLI-1:0]        rvalid_o,
  output logic [DWIDTH-1:0]      rdata_o,
  output logic [AWIDTH:0]        used_o,
  output logic                   lifo_srst_o,
  output logic                   lifo_wrreq_o,
  output logic                   lifo_rdreq_o,
  output logic [DWIDTH-1:0]      lifo_data_o,
  input  logic [DWIDTH-1:0]      lifo_q_i
);
  localparam int DEPTH = 2 ** AWIDTH;
  localparam int IW    = $clog2(NCLI);
  localparam int FW    = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;
  state_t              state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       win;
  logic                any;
  logic                flush_go;
  logic                ret;
  logic [AWIDTH:0]     count;
  logic [FW-1:0]       fcnt;
  logic [RD_LAT-1:0]   pv;
  logic [IW-1:0]       pidx [RD_LAT];
  assign used_o = count;
  always_comb begin
    win = '0;
    any = |req_i;
    for (int i = NCLI - 1; i >= 0; i--)
      if (req_i[(int'(rr_ptr) + i) % NCLI]) win = IW'((int'(rr_ptr) + i) % NCLI);
    flush_go = (state == IDLE) && flush_i;
    ret = pv[RD_LAT-1] && !flush_go;
  end
  // Outputs for the ISSUE cycle are decided on the IDLE edge so they appear registered.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      count        <= '0;
      fcnt         <= '0;
      pv           <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx[i] <= '0;
      gnt_o        <= '0;
      err_o        <= '0;
      rvalid_o     <= '0;
      rdata_o      <= '0;
      lifo_srst_o  <= 1'b0;
      lifo_wrreq_o <= 1'b0;
      lifo_rdreq_o <= 1'b0;
      lifo_data_o  <= '0;
    end else begin
      gnt_o        <= '0;
      err_o        <= '0;
      lifo_wrreq_o <= 1'b0;
      lifo_rdreq_o <= 1'b0;
      rvalid_o     <= '0;
      if (ret) begin
        rvalid_o[pidx[RD_LAT-1]] <= 1'b1;
        rdata_o                  <= lifo_q_i;
      end
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
      pv[0] <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_i) begin
            state       <= FLUSH;
            lifo_srst_o <= 1'b1;
            fcnt        <= FW'(RD_LAT - 1);
            count       <= '0;
            pv          <= '0;
          end else if (any) begin
            state      <= ISSUE;
            rr_ptr     <= (win == IW'(NCLI - 1)) ? '0 : win + 1'b1;
            gnt_o[win] <= 1'b1;
            if (op_i[win]) begin
              if (count != (AWIDTH+1)'(DEPTH)) begin
                lifo_wrreq_o <= 1'b1;
                lifo_data_o  <= data_i[int'(win)*DWIDTH +: DWIDTH];
                count        <= count + 1'b1;
              end else err_o[win] <= 1'b1;
            end else if (count != '0) begin
              lifo_rdreq_o <= 1'b1;
              count        <= count - 1'b1;
              pv[0]        <= 1'b1;
              pidx[0]      <= win;
            end else err_o[win] <= 1'b1;
          end
        end
        ISSUE: state <= IDLE;
        FLUSH: begin
          if (fcnt == '0) begin
            state       <= IDLE;
            lifo_srst_o <= 1'b0;
          end else fcnt <= fcnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter: directed bench for lifo_arbiter with a small behavioural LIFO attached.
module tb_lifo_arbiter;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  op = '0;
  logic [15:0] dat = '0;
  logic [1:0]  gnt, err, rvalid;
  logic [7:0]  rdata, ldata, lq;
  logic [3:0]  used;
  logic        srst, wr, rd;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int rd_t[$];
  int rv_t[$];
  logic [1:0] rv_who[$];
  logic [7:0] rv_dat[$];
  logic [7:0] mem [8];
  int         sp;
  logic [7:0] q0, q1;

  lifo_arbiter #(.DWIDTH(8), .AWIDTH(3), .NCLI(2), .RD_LAT(3)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush), .req_i(req), .op_i(op), .data_i(dat),
    .gnt_o(gnt), .err_o(err), .rvalid_o(rvalid), .rdata_o(rdata), .used_o(used),
    .lifo_srst_o(srst), .lifo_wrreq_o(wr), .lifo_rdreq_o(rd), .lifo_data_o(ldata), .lifo_q_i(lq)
  );

  always #5 clk = ~clk;

  // Behavioural LIFO: pop data reaches lq two edges after the strobe is sampled.
  assign lq = q1;
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sp <= 0; q0 <= '0; q1 <= '0;
    end else begin
      q1 <= q0;
      if (srst) begin
        sp <= 0; q0 <= '0;
      end else begin
        if (wr && sp < 8) begin mem[sp] <= ldata; sp <= sp + 1; end
        if (rd && sp > 0) begin q0 <= mem[sp-1]; sp <= sp - 1; end
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (wr) wr_cnt++;
    if (rd) begin rd_cnt++; rd_t.push_back(cyc); end
    if (|rvalid) begin rv_t.push_back(cyc); rv_who.push_back(rvalid); rv_dat.push_back(rdata); end
  end

  task automatic apply_reset;
    arst_n = 1'b0; req = '0; op = '0; flush = 1'b0; dat = '0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    wr_cnt = 0; rd_cnt = 0;
    rd_t.delete(); rv_t.delete(); rv_who.delete(); rv_dat.delete();
  endtask

  task automatic do_op(input int c, input logic o, input logic [7:0] d, input logic exp_err);
    int n;
    req[c] = 1'b1; op[c] = o; dat[c*8 +: 8] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[c] && n < 20);
    checks++;
    if (gnt[c] !== 1'b1) begin errors++; $display("FAIL op_grant c%0d: got gnt %b expected grant within 20 cycles", c, gnt); end
    checks++;
    if (err[c] !== exp_err) begin errors++; $display("FAIL op_err c%0d: got %b expected %b", c, err[c], exp_err); end
    req[c] = 1'b0;
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    #3;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b expected 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b expected 00", rvalid); end
    checks++; if (used !== 4'd0) begin errors++; $display("FAIL rst_used: got %0d expected 0", used); end
    checks++; if ({srst, wr, rd} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b expected 000", {srst, wr, rd}); end
    apply_reset;
    checks++; if ({err, rdata, ldata} !== 18'd0) begin errors++; $display("FAIL rst_data: got %h expected 0", {err, rdata, ldata}); end
  endtask

  task automatic test_push_pop;
    apply_reset;
    do_op(0, 1'b1, 8'h11, 1'b0);
    do_op(0, 1'b1, 8'h22, 1'b0);
    do_op(0, 1'b1, 8'h33, 1'b0);
    @(negedge clk);
    checks++; if (used !== 4'd3) begin errors++; $display("FAIL pp_used3: got %0d expected 3", used); end
    checks++; if (wr_cnt !== 3) begin errors++; $display("FAIL pp_wrcnt: got %0d expected 3", wr_cnt); end
    repeat (3) do_op(0, 1'b0, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    checks++; if (used !== 4'd0) begin errors++; $display("FAIL pp_used0: got %0d expected 0", used); end
    checks++;
    if (rv_t.size() !== 3 || rd_t.size() !== 3) begin
      errors++; $display("FAIL pp_returns: got %0d returns/%0d pops expected 3/3", rv_t.size(), rd_t.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [7:0] e;
        e = (i == 0) ? 8'h33 : (i == 1) ? 8'h22 : 8'h11;
        checks++; if (rv_dat[i] !== e) begin errors++; $display("FAIL pp_rdata%0d: got %h expected %h", i, rv_dat[i], e); end
        checks++; if (rv_who[i] !== 2'b01) begin errors++; $display("FAIL pp_rvalid%0d: got %b expected 01", i, rv_who[i]); end
        checks++; if (rv_t[i] - rd_t[i] !== 3) begin errors++; $display("FAIL pp_lat%0d: got %0d expected 3", i, rv_t[i] - rd_t[i]); end
      end
    end
  endtask

  task automatic test_round_robin;
    int ng, last;
    logic [1:0] exp;
    apply_reset;
    req = 2'b11; op = 2'b11; dat = 16'hB0A0;
    ng = 0; last = 0;
    for (int t = 0; t < 40 && ng < 9; t++) begin
      @(negedge clk);
      if (|gnt) begin
        exp = ng[0] ? 2'b10 : 2'b01;
        checks++; if (gnt !== exp) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", ng, gnt, exp); end
        if (ng > 0) begin
          checks++; if (t - last !== 2) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected 2", ng, t - last); end
        end
        checks++; if (err !== (ng == 8 ? exp : 2'b00)) begin errors++; $display("FAIL rr_err%0d: got %b", ng, err); end
        checks++; if (wr !== (ng < 8)) begin errors++; $display("FAIL rr_wrreq%0d: got %b expected %b", ng, wr, ng < 8); end
        last = t; ng++;
        if (ng == 9) req = '0;
      end
    end
    req = '0;
    @(negedge clk);
    checks++; if (ng !== 9) begin errors++; $display("FAIL rr_count: got %0d grants expected 9", ng); end
    checks++; if (used !== 4'd8) begin errors++; $display("FAIL rr_used: got %0d expected 8", used); end
    checks++; if (wr_cnt !== 8) begin errors++; $display("FAIL rr_wrcnt: got %0d expected 8", wr_cnt); end
  endtask

  task automatic test_underflow;
    apply_reset;
    do_op(1, 1'b0, 8'h00, 1'b1);
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL uf_rdreq: got %b expected 0", rd); end
    repeat (6) @(negedge clk);
    checks++; if (rv_t.size() !== 0) begin errors++; $display("FAIL uf_rvalid: got %0d returns expected 0", rv_t.size()); end
    checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL uf_rdcnt: got %0d expected 0", rd_cnt); end
    checks++; if (used !== 4'd0) begin errors++; $display("FAIL uf_used: got %0d expected 0", used); end
  endtask

  task automatic test_routing;
    apply_reset;
    do_op(0, 1'b1, 8'hA5, 1'b0);
    do_op(1, 1'b0, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (rv_t.size() !== 1) begin
      errors++; $display("FAIL rt_returns: got %0d expected 1", rv_t.size());
    end else begin
      checks++; if (rv_who[0] !== 2'b10) begin errors++; $display("FAIL rt_rvalid: got %b expected 10", rv_who[0]); end
      checks++; if (rv_dat[0] !== 8'hA5) begin errors++; $display("FAIL rt_rdata: got %h expected a5", rv_dat[0]); end
    end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rt_hold: got %h expected a5", rdata); end
  endtask

  task automatic test_flush;
    int nsr, got;
    apply_reset;
    for (int i = 0; i < 5; i++) do_op(0, 1'b1, 8'h40 + 8'(i), 1'b0);
    do_op(0, 1'b0, 8'h00, 1'b0);
    checks++; if (used !== 4'd4) begin errors++; $display("FAIL fl_used4: got %0d expected 4", used); end
    flush = 1'b1; req[1] = 1'b1; op[1] = 1'b1; dat[15:8] = 8'h77;
    nsr = 0; got = 0;
    for (int t = 0; t < 12 && got == 0; t++) begin
      @(negedge clk);
      if (srst) begin
        nsr++; flush = 1'b0;
        checks++; if (used !== 4'd0) begin errors++; $display("FAIL fl_used0: got %0d expected 0", used); end
      end
      if (gnt[1]) begin
        got = 1; req[1] = 1'b0;
        checks++; if (nsr !== 3) begin errors++; $display("FAIL fl_order: got %0d srst cycles before grant expected 3", nsr); end
        checks++; if (used !== 4'd1) begin errors++; $display("FAIL fl_used1: got %0d expected 1", used); end
      end
    end
    flush = 1'b0; req = '0;
    repeat (4) @(negedge clk);
    checks++; if (got !== 1) begin errors++; $display("FAIL fl_pending: got %0d grants expected 1", got); end
    checks++; if (rv_t.size() !== 0) begin errors++; $display("FAIL fl_rvalid: got %0d returns expected 0", rv_t.size()); end
  endtask

  task automatic test_async_reset;
    apply_reset;
    do_op(0, 1'b1, 8'h01, 1'b0);
    do_op(0, 1'b1, 8'h02, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; op[0] = 1'b1; dat[7:0] = 8'h03;
    @(negedge clk);
    checks++; if ({gnt[0], wr} !== 2'b11) begin errors++; $display("FAIL ar_issue: got %b expected 11", {gnt[0], wr}); end
    arst_n = 1'b0;
    #1;
    checks++; if ({gnt, err, wr, rd, srst} !== 7'd0) begin errors++; $display("FAIL ar_abort: got %b expected 0", {gnt, err, wr, rd, srst}); end
    checks++; if (used !== 4'd0) begin errors++; $display("FAIL ar_used: got %0d expected 0", used); end
    req = '0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    checks++; if ({gnt, wr, rd} !== 4'd0) begin errors++; $display("FAIL ar_release: got %b expected 0", {gnt, wr, rd}); end
    do_op(0, 1'b1, 8'h55, 1'b0);
    checks++; if (used !== 4'd1) begin errors++; $display("FAIL ar_used1: got %0d expected 1", used); end
  endtask

  initial begin
    test_reset;
    test_push_pop;
    test_round_robin;
    test_underflow;
    test_routing;
    test_flush;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
